arcfour_encryptor: RTL and testbench
====================================

// Module: arcfour_encryptor
// PURPOSE
//  Transmit-side counterpart of the RC4 decryption/key-search path.
//  - Takes a known key and runs KSA (init + shuffle) on S-RAM.
//  - Runs PRGA over a plaintext ROM and writes the ciphertext into C-RAM.
//  - Its output image is what the decrypt/crack path consumes as its encrypted-message ROM.
// PARAMETERS
//  RAM_WIDTH           8   byte width of all memories and key bytes
//  KEY_LENGTH          3   key length in bytes
//  MESSAGE_LENGTH      32  plaintext/ciphertext length in bytes
//  MESSAGE_LOG_LENGTH  5   address width of P-ROM and C-RAM
// PORTS
//  clk     in   1                       clock, rising edge
//  reset   in   1                       asynchronous, active-high
//  start   in   1                       level input; rising edge launches one encryption
//  key     in   KEY_LENGTH x RAM_WIDTH  key; key[KEY_LENGTH-1] is key byte 0; sampled on start edge
//  busy    out  1                       high in INIT/SHUFFLE/ENCRYPT
//  done    out  1                       high in DONE until next accepted start
//  sAddr   out  RAM_WIDTH               S-RAM address
//  sIn     out  RAM_WIDTH               S-RAM write data
//  sWren   out  1                       S-RAM write enable
//  sOut    in   RAM_WIDTH               S-RAM read data; 1-cycle read latency
//  pAddr   out  MESSAGE_LOG_LENGTH      P-ROM address
//  pOut    in   RAM_WIDTH               P-ROM data; 1-cycle latency
//  cAddr   out  MESSAGE_LOG_LENGTH      C-RAM address
//  cIn     out  RAM_WIDTH               C-RAM write data
//  cWren   out  1                       C-RAM write enable
// BEHAVIOUR
//  Reset (async, any time)
//  - State -> IDLE; all outputs 0; i, j, k, latched key cleared.
//  - Mid-operation reset abandons the run; partial S/C contents are don't-care.
//  Start
//  - start is edge-detected internally.
//  - Rising edge in IDLE or DONE: latch key, clear done, go to INIT.
//  - Edges while busy are ignored.
//  INIT
//  - s[i] = i for i = 0..255; one write per cycle, 256 cycles.
//  - i wraps 255 -> 0, then go to SHUFFLE with j = 0.
//  SHUFFLE: 6 cycles per i, i = 0..255
//  - RDI: sAddr = i.
//  - WTI: si <= sOut; j <= j + si + keybyte[i mod KEY_LENGTH] (mod 256).
//  - RDJ: sAddr = j.
//  - WTJ: sj <= sOut.
//  - WRI: s[i] = sj.
//  - WRJ: s[j] = si.
//  - After i = 255 go to ENCRYPT with i = 0, j = 0, k = 0.
//  ENCRYPT: 9 cycles per byte k, k = 0..MESSAGE_LENGTH-1
//  - RDI: i <= i + 1; sAddr = i + 1.
//  - WTI: capture si; j <= j + si.
//  - RDJ: sAddr = j.
//  - WTJ: capture sj.
//  - WRI: s[i] = sj.
//  - WRJ: s[j] = si; pAddr = k.
//  - RDF: sAddr = si + sj (mod 256).
//  - WTF: capture f = sOut and p = pOut.
//  - WRC: cAddr = k; cIn = f ^ p; cWren = 1.
//  - After k = MESSAGE_LENGTH-1 go to DONE.
//  Width and boundary rules
//  - All index arithmetic is mod 256; 8-bit overflow is intended.
//  - The i == j swap case is legal: both writes go to the same address and s is unchanged.
//  - At most one of sWren and cWren is high per cycle; each is high for exactly one cycle per write.
//  - The key-byte index is a separate mod-KEY_LENGTH counter, never a divider.
//  - Latency for a 32-byte message: 256 + 1536 + 288 = 2080 cycles from start edge to done rising (±1 for the edge detector).
// STRUCTURE
//  - arcfour_pkg: state enum (IDLE, INIT, SHUFFLE, ENCRYPT, DONE), substep enum (RDI..WRC), S_LENGTH = 256.
//    The same package is shared with the decrypt controller.
//  - Reuse the existing edge_detector for start; no new sub-module.
//  - One FSM plus a datapath with registers i, j, k, si, sj, f, kidx.
// TESTING
//  1. KEY_LENGTH=3, key 4B_65_79 ("Key"), MESSAGE_LENGTH=9, P = "Plaintext"
//     -> C = BB F3 16 E8 D9 40 AF 0A D3; done high.
//  2. KEY_LENGTH=4, key "Wiki", MESSAGE_LENGTH=5, P = "pedia"
//     -> C = 10 21 BF 04 20.
//  3. Round trip: feed C from test 1 back as P with the same key -> C-RAM equals "Plaintext".
//  4. start edge pulsed during SHUFFLE
//     -> ignored; result and cycle count identical to test 1.
//  5. reset asserted in ENCRYPT at k=4 -> outputs 0 and IDLE on the same edge.
//     A new start then gives the full correct result.
//  6. start held high across DONE -> no restart.
//     Release, then re-press -> second run; done drops for that run, then returns.
//  All tests: SVA checks that sWren & cWren never overlap and that busy & done are exclusive.

Source files
------------

// File: rtl/arcfour_pkg.sv
// arcfour_pkg: state and sub-step encodings shared by the RC4
// encrypt and decrypt controllers.
package arcfour_pkg;

    localparam int S_LENGTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHUFFLE,
        ENCRYPT,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        RDI,
        WTI,
        RDJ,
        WTJ,
        WRI,
        WRJ,
        RDF,
        WTF,
        WRC
    } step_t;

endpackage

// File: rtl/edge_detector.sv
// edge_detector: one-cycle rise pulse for a level input.
// Ports: clk, reset (async, active-high), sig_in, rise.
module edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/arcfour_encryptor.sv
// arcfour_encryptor: RC4 KSA over S-RAM, then PRGA over P-ROM into C-RAM.
// Ports: clk, reset, start, key, busy, done, S/P/C memory buses.
module arcfour_encryptor
    import arcfour_pkg::*;
#(
    parameter int RAM_WIDTH          = 8,
    parameter int KEY_LENGTH         = 3,
    parameter int MESSAGE_LENGTH     = 32,
    parameter int MESSAGE_LOG_LENGTH = 5
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
    output logic                                 busy,
    output logic                                 done,
    output logic [RAM_WIDTH-1:0]                 sAddr,
    output logic [RAM_WIDTH-1:0]                 sIn,
    output logic                                 sWren,
    input  logic [RAM_WIDTH-1:0]                 sOut,
    output logic [MESSAGE_LOG_LENGTH-1:0]        pAddr,
    input  logic [RAM_WIDTH-1:0]                 pOut,
    output logic [MESSAGE_LOG_LENGTH-1:0]        cAddr,
    output logic [RAM_WIDTH-1:0]                 cIn,
    output logic                                 cWren
);

    localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam int MW = MESSAGE_LOG_LENGTH;
    localparam logic [RAM_WIDTH-1:0] I_LAST = RAM_WIDTH'(S_LENGTH - 1);
    localparam logic [KW-1:0] KIDX_LAST = KW'(KEY_LENGTH - 1);
    localparam logic [MW-1:0] K_LAST = MW'(MESSAGE_LENGTH - 1);

    state_t state_q, state_d;
    step_t  step_q, step_d;
    logic [RAM_WIDTH-1:0] i_q, i_d, j_q, j_d;
    logic [RAM_WIDTH-1:0] si_q, si_d, sj_q, sj_d;
    logic [RAM_WIDTH-1:0] f_q, f_d, p_q, p_d;
    logic [MW-1:0] k_q, k_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key_q, key_d;
    logic [RAM_WIDTH-1:0] kbyte;
    logic start_rise;
    logic enc;

    edge_detector u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (start),
        .rise   (start_rise)
    );

    // key byte 0 sits in the top slot of the packed key
    always_comb begin
        kbyte = '0;
        for (int n = 0; n < KEY_LENGTH; n++) begin
            if (kidx_q == KW'(n)) begin
                kbyte = key_q[KEY_LENGTH-1-n];
            end
        end
    end

    assign enc  = (state_q == ENCRYPT);
    assign busy = state_q inside {INIT, SHUFFLE, ENCRYPT};
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        p_d     = p_q;
        k_d     = k_q;
        kidx_d  = kidx_q;
        key_d   = key_q;
        sAddr   = '0;
        sIn     = '0;
        sWren   = 1'b0;
        pAddr   = '0;
        cAddr   = '0;
        cIn     = '0;
        cWren   = 1'b0;

        // hold pAddr for the whole byte so the ROM latency is covered
        if (enc) begin
            pAddr = k_q;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    key_d   = key;
                    state_d = INIT;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    kidx_d  = '0;
                end
            end
            INIT: begin
                sAddr = i_q;
                sIn   = i_q;
                sWren = 1'b1;
                i_d   = i_q + 1'b1;
                if (i_q == I_LAST) begin
                    state_d = SHUFFLE;
                    step_d  = RDI;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end
            SHUFFLE, ENCRYPT: begin
                unique case (step_q)
                    RDI: begin
                        step_d = WTI;
                        if (enc) begin
                            i_d   = i_q + 1'b1;
                            sAddr = i_q + 1'b1;
                        end else begin
                            sAddr = i_q;
                        end
                    end
                    WTI: begin
                        step_d = RDJ;
                        si_d   = sOut;
                        j_d    = enc ? j_q + sOut
                                     : j_q + sOut + kbyte;
                    end
                    RDJ: begin
                        step_d = WTJ;
                        sAddr  = j_q;
                    end
                    WTJ: begin
                        step_d = WRI;
                        sj_d   = sOut;
                    end
                    WRI: begin
                        step_d = WRJ;
                        sAddr  = i_q;
                        sIn    = sj_q;
                        sWren  = 1'b1;
                    end
                    WRJ: begin
                        sAddr = j_q;
                        sIn   = si_q;
                        sWren = 1'b1;
                        if (enc) begin
                            step_d = RDF;
                        end else begin
                            step_d = RDI;
                            i_d    = i_q + 1'b1;
                            kidx_d = (kidx_q == KIDX_LAST)
                                   ? '0 : kidx_q + 1'b1;
                            if (i_q == I_LAST) begin
                                state_d = ENCRYPT;
                                i_d     = '0;
                                j_d     = '0;
                                k_d     = '0;
                            end
                        end
                    end
                    RDF: begin
                        step_d = WTF;
                        sAddr  = si_q + sj_q;
                    end
                    WTF: begin
                        step_d = WRC;
                        f_d    = sOut;
                        p_d    = pOut;
                    end
                    WRC: begin
                        step_d = RDI;
                        cAddr  = k_q;
                        cIn    = f_q ^ p_q;
                        cWren  = 1'b1;
                        k_d    = k_q + 1'b1;
                        if (k_q == K_LAST) begin
                            state_d = DONE;
                        end
                    end
                    default: step_d = RDI;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= RDI;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            p_q     <= '0;
            k_q     <= '0;
            kidx_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            p_q     <= p_d;
            k_q     <= k_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
        end
    end

endmodule

// File: tb/tb_arcfour_encryptor.sv
// tb_arcfour_encryptor: directed RC4 vectors against two encryptor
// instances (3-byte key / 9-byte message, 4-byte key / 5-byte message).
module tb_arcfour_encryptor;

    logic clk = 1'b0;
    logic reset;
    logic a_start, b_start;
    logic [2:0][7:0] a_key;
    logic [3:0][7:0] b_key;

    logic a_busy, a_done, a_sWren, a_cWren;
    logic [7:0] a_sAddr, a_sIn, a_sOut, a_pOut, a_cIn;
    logic [4:0] a_pAddr, a_cAddr;
    logic b_busy, b_done, b_sWren, b_cWren;
    logic [7:0] b_sAddr, b_sIn, b_sOut, b_pOut, b_cIn;
    logic [4:0] b_pAddr, b_cAddr;

    logic [7:0] a_s [256];
    logic [7:0] a_p [32];
    logic [7:0] a_c [32];
    logic [7:0] b_s [256];
    logic [7:0] b_p [32];
    logic [7:0] b_c [32];
    logic a_clr;

    int n_checks = 0;
    int n_fail = 0;
    int viol = 0;
    int a_cw = 0;

    logic [37:0] a_outs, b_outs;
    assign a_outs = {a_busy, a_done, a_sWren, a_cWren, a_sAddr,
                     a_sIn, a_pAddr, a_cAddr, a_cIn};
    assign b_outs = {b_busy, b_done, b_sWren, b_cWren, b_sAddr,
                     b_sIn, b_pAddr, b_cAddr, b_cIn};

    logic [7:0] pt   [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E,
                             8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ct1  [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9,
                             8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] pt2  [5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    logic [7:0] ct2  [5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};

    arcfour_encryptor #(
        .RAM_WIDTH(8), .KEY_LENGTH(3),
        .MESSAGE_LENGTH(9), .MESSAGE_LOG_LENGTH(5)
    ) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .key(a_key),
        .busy(a_busy), .done(a_done),
        .sAddr(a_sAddr), .sIn(a_sIn), .sWren(a_sWren), .sOut(a_sOut),
        .pAddr(a_pAddr), .pOut(a_pOut),
        .cAddr(a_cAddr), .cIn(a_cIn), .cWren(a_cWren)
    );

    arcfour_encryptor #(
        .RAM_WIDTH(8), .KEY_LENGTH(4),
        .MESSAGE_LENGTH(5), .MESSAGE_LOG_LENGTH(5)
    ) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .key(b_key),
        .busy(b_busy), .done(b_done),
        .sAddr(b_sAddr), .sIn(b_sIn), .sWren(b_sWren), .sOut(b_sOut),
        .pAddr(b_pAddr), .pOut(b_pOut),
        .cAddr(b_cAddr), .cIn(b_cIn), .cWren(b_cWren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_sWren) a_s[a_sAddr] <= a_sIn;
        a_sOut <= a_s[a_sAddr];
        a_pOut <= a_p[a_pAddr];
        if (a_clr) begin
            for (int n = 0; n < 32; n++) a_c[n] <= 8'h00;
        end else if (a_cWren) begin
            a_c[a_cAddr] <= a_cIn;
        end
        if (b_sWren) b_s[b_sAddr] <= b_sIn;
        b_sOut <= b_s[b_sAddr];
        b_pOut <= b_p[b_pAddr];
        if (b_cWren) b_c[b_cAddr] <= b_cIn;
    end

    // write-enable and busy/done exclusivity monitor
    always @(negedge clk) begin
        if (!reset) begin
            if ((a_sWren && a_cWren) || (a_busy && a_done) ||
                (b_sWren && b_cWren) || (b_busy && b_done))
                viol <= viol + 1;
            if (a_cWren) a_cw <= a_cw + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_c();
        @(negedge clk);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
    endtask

    task automatic start_run(input bit sel);
        @(negedge clk);
        if (sel) b_start = 1'b0; else a_start = 1'b0;
        @(negedge clk);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
    endtask

    task automatic wait_done(input bit sel, input int limit,
                             input int pulse_at, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sel ? b_done : a_done) break;
            if (!sel && pulse_at != 0) begin
                if (cyc == pulse_at) a_start = 1'b0;
                if (cyc == pulse_at + 1) a_start = 1'b1;
            end
        end
    endtask

    task automatic chk_a(input string tag, input logic [7:0] e [9]);
        for (int n = 0; n < 9; n++)
            chk($sformatf("%s[%0d]", tag, n), a_c[n], e[n]);
    endtask

    int cyc;
    int cw0;
    int nb;
    bit found;

    initial begin
        reset   = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        a_clr   = 1'b0;
        a_key   = {8'h4B, 8'h65, 8'h79};
        b_key   = {8'h57, 8'h69, 8'h6B, 8'h69};
        for (int n = 0; n < 9; n++) a_p[n] = pt[n];
        for (int n = 0; n < 5; n++) b_p[n] = pt2[n];
        for (int n = 0; n < 32; n++) b_c[n] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_a", 64'(a_outs), 64'd0);
        chk("reset_outs_b", 64'(b_outs), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: "Key" / "Plaintext"
        clear_c();
        cw0 = a_cw;
        start_run(0);
        wait_done(0, 4000, 0, cyc);
        chk("t1_cycles", cyc, 1874);
        chk("t1_done", a_done, 1'b1);
        chk("t1_busy", a_busy, 1'b0);
        chk("t1_cwren_count", a_cw - cw0, 9);
        chk_a("t1_c", ct1);

        // 2: "Wiki" / "pedia"
        start_run(1);
        wait_done(1, 4000, 0, cyc);
        chk("t2_cycles", cyc, 1838);
        chk("t2_done", b_done, 1'b1);
        for (int n = 0; n < 5; n++)
            chk($sformatf("t2_c[%0d]", n), b_c[n], ct2[n]);

        // 3: round trip
        for (int n = 0; n < 9; n++) a_p[n] = ct1[n];
        clear_c();
        start_run(0);
        wait_done(0, 4000, 0, cyc);
        chk("t3_cycles", cyc, 1874);
        chk_a("t3_c", pt);
        for (int n = 0; n < 9; n++) a_p[n] = pt[n];

        // 4: start edge during SHUFFLE is ignored
        clear_c();
        start_run(0);
        wait_done(0, 4000, 500, cyc);
        chk("t4_cycles", cyc, 1874);
        chk_a("t4_c", ct1);

        // 5: reset mid-ENCRYPT at k=4
        clear_c();
        start_run(0);
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(posedge clk);
            #1;
            if (a_cWren && a_cAddr == 5'd3) found = 1'b1;
        end
        chk("t5_reached_k3", found, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_busy_pre", a_busy, 1'b1);
        chk("t5_wr_k3", a_c[3], ct1[3]);
        chk("t5_no_k4", a_c[4], 8'h00);
        reset = 1'b1;
        #1;
        chk("t5_reset_outs", 64'(a_outs), 64'd0);
        a_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clear_c();
        start_run(0);
        wait_done(0, 4000, 0, cyc);
        chk("t5_cycles", cyc, 1874);
        chk_a("t5_c", ct1);

        // 6: start held across DONE, then re-press
        nb = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (a_busy) nb++;
        end
        chk("t6_no_restart", nb, 0);
        chk("t6_done_held", a_done, 1'b1);
        clear_c();
        start_run(0);
        @(posedge clk);
        #1;
        chk("t6_done_drop", a_done, 1'b0);
        chk("t6_busy", a_busy, 1'b1);
        wait_done(0, 4000, 0, cyc);
        chk("t6_cycles", cyc, 1873);
        chk("t6_done_back", a_done, 1'b1);
        chk_a("t6_c", ct1);

        chk("exclusive_monitor", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
